// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment receive path.
// Segment codes are active-low with bit 0 = segment a, bit 6 = segment g.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DEC_HEX   = 2'd0,
    DEC_BLANK = 2'd1,
    DEC_BAD   = 2'd2
  } dec_class_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Inverse of the hex-to-segment encoder: classifies a 7-bit active-low
// pattern as a hex digit, a blank, or an unrecognised code.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output dec_class_t cls_o,
  output logic [3:0] val_o
);

  always_comb begin
    cls_o = DEC_HEX;
    val_o = '0;
    case (seg_i)
      SEG_0:     val_o = 4'h0;
      SEG_1:     val_o = 4'h1;
      SEG_2:     val_o = 4'h2;
      SEG_3:     val_o = 4'h3;
      SEG_4:     val_o = 4'h4;
      SEG_5:     val_o = 4'h5;
      SEG_6:     val_o = 4'h6;
      SEG_7:     val_o = 4'h7;
      SEG_8:     val_o = 4'h8;
      SEG_9:     val_o = 4'h9;
      SEG_A:     val_o = 4'hA;
      SEG_B:     val_o = 4'hB;
      SEG_C:     val_o = 4'hC;
      SEG_D:     val_o = 4'hD;
      SEG_E:     val_o = 4'hE;
      SEG_F:     val_o = 4'hF;
      SEG_BLANK: cls_o = DEC_BLANK;
      default:   cls_o = DEC_BAD;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive side of a scanned seven-segment bus: debounces each one-hot digit
// slot, decodes the stable pattern and keeps a per-digit register bank.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 6,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_ok,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    upd,
  output logic                    frame_done
);

  localparam int unsigned        CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(STABLE_CYCLES);

  logic [6:0]              s_seg_q, p_seg_q;
  logic [NUM_DIGITS-1:0]   s_sel_q, p_sel_q;
  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   ok_q, ok_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    upd_q, upd_d;
  logic                    fd_q, fd_d;

  logic       sel_one_hot;
  logic       same_sample;
  logic       commit;
  dec_class_t dec_cls;
  logic [3:0] dec_val;

  seg7_to_hex u_dec (
    .seg_i (s_seg_q),
    .cls_o (dec_cls),
    .val_o (dec_val)
  );

  assign sel_one_hot = $onehot(s_sel_q);
  assign same_sample = (s_seg_q == p_seg_q) && (s_sel_q == p_sel_q);

  // The p_* registers hold the previous sample, so a run counts consecutive
  // cycles in which the registered sample stayed identical.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    if (!sel_one_hot) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (!same_sample || state_q == IDLE) begin
      state_d = SETTLE;
      cnt_d   = CNT_ONE;
    end else if (state_q == SETTLE && cnt_q != CNT_FULL) begin
      cnt_d = cnt_q + CNT_ONE;
      if (cnt_d == CNT_FULL) begin
        commit  = 1'b1;
        state_d = HOLD;
      end
    end
  end

  always_comb begin
    digits_d = digits_q;
    ok_d     = ok_q;
    err_d    = err_q;
    seen_d   = seen_q;
    upd_d    = 1'b0;
    fd_d     = 1'b0;
    if (commit) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (s_sel_q[i]) begin
          case (dec_cls)
            DEC_HEX: begin
              digits_d[4*i +: 4] = dec_val;
              ok_d[i]            = 1'b1;
              err_d[i]           = 1'b0;
            end
            DEC_BLANK: begin
              digits_d[4*i +: 4] = '0;
              ok_d[i]            = 1'b0;
              err_d[i]           = 1'b0;
            end
            default: begin
              ok_d[i]  = 1'b0;
              err_d[i] = 1'b1;
            end
          endcase
        end
      end
      upd_d  = (digits_d != digits_q) || (ok_d != ok_q) || (err_d != err_q);
      seen_d = seen_q | s_sel_q;
      if (&seen_d) begin
        fd_d   = 1'b1;
        seen_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_seg_q  <= '0;
      s_sel_q  <= '0;
      p_seg_q  <= '0;
      p_sel_q  <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      digits_q <= '0;
      ok_q     <= '0;
      err_q    <= '0;
      seen_q   <= '0;
      upd_q    <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      s_seg_q  <= seg;
      s_sel_q  <= dig_sel;
      p_seg_q  <= s_seg_q;
      p_sel_q  <= s_sel_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      seen_q   <= seen_d;
      upd_q    <= upd_d;
      fd_q     <= fd_d;
    end
  end

  assign digits     = digits_q;
  assign digit_ok   = ok_q;
  assign digit_err  = err_q;
  assign upd        = upd_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: run-length reference model checked every
// cycle, a decode vector table, directed corner sequences and random scans.
module tb_seg7_scan_decoder;

  localparam int N = 6;
  localparam int S = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [6:0]     seg;
  logic [N-1:0]   dig_sel;
  logic [4*N-1:0] digits;
  logic [N-1:0]   digit_ok, digit_err;
  logic           upd, frame_done;

  seg7_scan_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg        (seg),
    .dig_sel    (dig_sel),
    .digits     (digits),
    .digit_ok   (digit_ok),
    .digit_err  (digit_err),
    .upd        (upd),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  logic [6:0] hexseg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: history of sampled bus values and the slot bank.
  logic [6:0]   hseg [$];
  logic [N-1:0] hsel [$];
  logic [3:0]   m_val [N];
  logic [N-1:0] m_ok, m_err, m_seen;
  logic         m_upd, m_fd;

  int vectors = 0;
  int miscompares = 0;
  int upd_cnt = 0;
  int fd_cnt = 0;
  bit saw3_slot2 = 0;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] val;
    logic       ok;
    logic       err;
  } vec_t;
  vec_t tbl [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hseg.delete();
    hsel.delete();
    hseg.push_back('0);
    hsel.push_back('0);
    for (int i = 0; i < N; i++) m_val[i] = '0;
    m_ok = '0; m_err = '0; m_seen = '0; m_upd = 0; m_fd = 0;
  endtask

  task automatic model_commit(input logic [6:0] sg, input int idx);
    logic [3:0] v; logic ok, er;
    int found;
    found = -1;
    for (int h = 0; h < 16; h++) if (hexseg[h] == sg) found = h;
    v = m_val[idx];
    if (found >= 0) begin v = 4'(found); ok = 1; er = 0; end
    else if (sg == 7'h7F) begin v = 0; ok = 0; er = 0; end
    else begin ok = 0; er = 1; end
    m_upd = (v != m_val[idx]) || (ok != m_ok[idx]) || (er != m_err[idx]);
    m_val[idx] = v; m_ok[idx] = ok; m_err[idx] = er;
    m_seen[idx] = 1'b1;
    if (m_seen == {N{1'b1}}) begin m_fd = 1; m_seen = '0; end
  endtask

  // At each edge the decoder judges the sample captured on the previous edge;
  // it commits when that sample is one-hot and has now been seen exactly S times in a row.
  task automatic model_edge();
    int run, idx;
    logic [6:0] sg; logic [N-1:0] sl;
    m_upd = 0; m_fd = 0;
    sg = hseg[hseg.size()-1];
    sl = hsel[hsel.size()-1];
    run = 0;
    for (int i = hseg.size()-1; i >= 0; i--) begin
      if (hseg[i] == sg && hsel[i] == sl) run++;
      else break;
    end
    if ($countones(sl) == 1 && run == S) begin
      idx = 0;
      for (int i = 0; i < N; i++) if (sl[i]) idx = i;
      model_commit(sg, idx);
    end
    hseg.push_back(seg);
    hsel.push_back(dig_sel);
    if (hseg.size() > S + 2) begin
      void'(hseg.pop_front());
      void'(hsel.pop_front());
    end
  endtask

  task automatic compare_all();
    logic [4*N-1:0] md;
    for (int i = 0; i < N; i++) md[4*i +: 4] = m_val[i];
    check("digits", 32'(digits), 32'(md));
    check("digit_ok", 32'(digit_ok), 32'(m_ok));
    check("digit_err", 32'(digit_err), 32'(m_err));
    check("upd", 32'(upd), 32'(m_upd));
    check("frame_done", 32'(frame_done), 32'(m_fd));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    compare_all();
    upd_cnt += int'(upd);
    fd_cnt  += int'(frame_done);
    if (digits[11:8] == 4'h3) saw3_slot2 = 1;
  endtask

  task automatic hold(input logic [N-1:0] sl, input logic [6:0] sg, input int n);
    dig_sel = sl;
    seg = sg;
    repeat (n) tick();
  endtask

  // Async reset asserted between edges, checked immediately, held over one edge.
  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_digits", 32'(digits), 0);
    check("rst_ok", 32'(digit_ok), 0);
    check("rst_err", 32'(digit_err), 0);
    check("rst_upd", 32'({upd, frame_done}), 0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int first;
    tbl[0]  = '{7'h40, 4'h0, 1'b1, 1'b0};
    tbl[1]  = '{7'h79, 4'h1, 1'b1, 1'b0};
    tbl[2]  = '{7'h24, 4'h2, 1'b1, 1'b0};
    tbl[3]  = '{7'h30, 4'h3, 1'b1, 1'b0};
    tbl[4]  = '{7'h19, 4'h4, 1'b1, 1'b0};
    tbl[5]  = '{7'h12, 4'h5, 1'b1, 1'b0};
    tbl[6]  = '{7'h02, 4'h6, 1'b1, 1'b0};
    tbl[7]  = '{7'h78, 4'h7, 1'b1, 1'b0};
    tbl[8]  = '{7'h00, 4'h8, 1'b1, 1'b0};
    tbl[9]  = '{7'h10, 4'h9, 1'b1, 1'b0};
    tbl[10] = '{7'h08, 4'hA, 1'b1, 1'b0};
    tbl[11] = '{7'h03, 4'hB, 1'b1, 1'b0};
    tbl[12] = '{7'h46, 4'hC, 1'b1, 1'b0};
    tbl[13] = '{7'h21, 4'hD, 1'b1, 1'b0};
    tbl[14] = '{7'h06, 4'hE, 1'b1, 1'b0};
    tbl[15] = '{7'h0E, 4'hF, 1'b1, 1'b0};
    tbl[16] = '{7'h55, 4'hF, 1'b0, 1'b1};
    tbl[17] = '{7'h7F, 4'h0, 1'b0, 1'b0};
    tbl[18] = '{7'h7E, 4'h0, 1'b0, 1'b1};

    rst = 1'b1;
    seg = 7'h7F;
    dig_sel = '0;
    model_reset();
    repeat (2) tick();
    rst = 1'b0;

    // Single digit commit, one upd pulse only.
    do_reset();
    upd_cnt = 0;
    hold(6'b000001, 7'h24, 6);
    check("t1_upd_pulses", upd_cnt, 1);
    check("t1_digit0", 32'(digits[3:0]), 2);
    check("t1_ok", 32'(digit_ok), 32'h01);

    // Full scan, frame_done on the slot 5 commit.
    fd_cnt = 0;
    for (int i = 0; i < N; i++) hold(6'(1 << i), hexseg[i], 5);
    hold('0, 7'h7F, 2);
    check("t2_digits", 32'(digits), 32'h543210);
    check("t2_ok", 32'(digit_ok), 32'h3F);
    check("t2_frame_pulses", fd_cnt, 1);

    // Glitch during settling on slot 2.
    hold(6'b000100, 7'h78, 6);
    upd_cnt = 0;
    saw3_slot2 = 0;
    hold(6'b000100, 7'h24, 2);
    hold(6'b000100, 7'h30, 1);
    hold(6'b000100, 7'h24, 4);
    hold('0, 7'h7F, 2);
    check("t3_upd_pulses", upd_cnt, 1);
    check("t3_never3", 32'(saw3_slot2), 0);
    check("t3_slot2", 32'(digits[11:8]), 2);

    // Multi-hot and zero select never commit.
    upd_cnt = 0;
    fd_cnt = 0;
    hold(6'b000011, 7'h40, 10);
    hold(6'b000000, 7'h40, 10);
    check("t4_upd_pulses", upd_cnt, 0);
    check("t4_frame_pulses", fd_cnt, 0);
    check("t4_digits", 32'(digits), 32'h543210);

    // Unknown code then blank on slot 1.
    hold(6'b000010, 7'h30, 6);
    upd_cnt = 0;
    hold(6'b000010, 7'h55, 6);
    check("t5_err1", 32'(digit_err[1]), 1);
    check("t5_ok1", 32'(digit_ok[1]), 0);
    check("t5_val1", 32'(digits[7:4]), 3);
    check("t5_upd_pulses", upd_cnt, 1);
    hold(6'b000010, 7'h7F, 6);
    check("t5_blank_err1", 32'(digit_err[1]), 0);
    check("t5_blank_ok1", 32'(digit_ok[1]), 0);
    check("t5_blank_val1", 32'(digits[7:4]), 0);

    // Reset mid-settle on slot 4; afterwards one input-register cycle plus S runs.
    hold(6'b010000, 7'h19, 2);
    do_reset();
    first = -1;
    for (int k = 1; k <= S + 3; k++) begin
      tick();
      if (upd && first < 0) first = k;
    end
    check("t6_latency", first, S + 1);
    check("t6_slot4", 32'(digits[19:16]), 4);

    // Decode table through slot 0.
    for (int t = 0; t < 19; t++) begin
      hold(6'b000001, tbl[t].seg, 6);
      check("tbl_val", 32'(digits[3:0]), 32'(tbl[t].val));
      check("tbl_ok", 32'(digit_ok[0]), 32'(tbl[t].ok));
      check("tbl_err", 32'(digit_err[0]), 32'(tbl[t].err));
    end

    // Random scanning against the model.
    for (int it = 0; it < 400; it++) begin
      int r;
      logic [N-1:0] sl;
      logic [6:0] sg;
      r = $urandom_range(0, 9);
      if (r == 0) sl = '0;
      else if (r == 1) sl = N'($urandom);
      else sl = N'(1 << $urandom_range(0, N-1));
      r = $urandom_range(0, 15);
      if (r < 11) sg = hexseg[$urandom_range(0, 15)];
      else if (r < 13) sg = 7'h7F;
      else sg = 7'($urandom);
      if ($urandom_range(0, 49) == 0) do_reset();
      hold(sl, sg, $urandom_range(1, 6));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
